sum_splitter: RTL and testbench

Inverse of the registered adder test block: accepts a stream of `(sum, in0)` pairs and recovers the missing operand `in1 = sum - in0` (mod 2^WIDTH). Results go out through a 2-entry output buffer under valid/ready flow control. Each recovered operand is checked against an expected value, and mismatches are counted. It sits downstream of the adder in the transformation regression benches, where it proves the adder path survived dead-code elimination.

---
 rtl/sum_splitter_if.sv | 25 ++
 rtl/sum_splitter.sv | 75 +++++++
 tb/tb_sum_splitter.sv | 196 +++++++++++++++++++
 3 files changed

// File: rtl/sum_splitter_if.sv
// Stream interface of sum_splitter: (sum, in0, exp_in1) beats in, recovered operand out.
// A beat transfers on a rising edge where valid & ready are both 1; the sender holds its payload
// stable while valid is 1 and ready is 0; ready never depends combinationally on valid.
interface sum_splitter_if #(
  parameter int WIDTH = 8
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] sum;
  logic [WIDTH-1:0] in0;
  logic [WIDTH-1:0] exp_in1;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out;

  modport master (
    output in_valid, sum, in0, exp_in1, out_ready,
    input  in_ready, out_valid, out
  );

  modport slave (
    input  in_valid, sum, in0, exp_in1, out_ready,
    output in_ready, out_valid, out
  );
endinterface

// File: rtl/sum_splitter.sv
// Recovers in1 = sum - in0 from an adder's result stream, buffers results in a 2-entry FIFO
// and counts beats whose recovered operand differs from the expected one.
module sum_splitter #(
  parameter int WIDTH     = 8,
  parameter int CNT_WIDTH = 4
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 clear,
  sum_splitter_if.slave        bus,
  output logic [CNT_WIDTH-1:0] mismatch_count,
  output logic                 error
);

  logic [WIDTH-1:0] mem [2];
  logic             wr_ptr;
  logic             rd_ptr;
  logic [1:0]       count;

  logic             acc;
  logic             pop;
  logic [WIDTH-1:0] diff;
  logic             mismatch;

  // Flow control derives only from count, so in_ready has no path from out_ready.
  assign bus.in_ready  = (count != 2'd2);
  assign bus.out_valid = (count != 2'd0);
  assign bus.out       = mem[rd_ptr];

  assign acc      = bus.in_valid & bus.in_ready;
  assign pop      = bus.out_valid & bus.out_ready;
  assign diff     = bus.sum - bus.in0;
  assign mismatch = (diff != bus.exp_in1);

  // Storage is not reset; out is only meaningful while out_valid is high.
  always_ff @(posedge clock) begin
    if (!reset && acc) begin
      mem[wr_ptr] <= diff;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      count  <= 2'd0;
    end else begin
      if (acc) begin
        wr_ptr <= ~wr_ptr;
      end
      if (pop) begin
        rd_ptr <= ~rd_ptr;
      end
      case ({acc, pop})
        2'b10:   count <= count + 2'd1;
        2'b01:   count <= count - 2'd1;
        default: count <= count;
      endcase
    end
  end

  // clear wins over a mismatch arriving in the same cycle.
  always_ff @(posedge clock) begin
    if (reset || clear) begin
      mismatch_count <= '0;
      error          <= 1'b0;
    end else if (acc && mismatch) begin
      error <= 1'b1;
      if (mismatch_count != '1) begin
        mismatch_count <= mismatch_count + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_sum_splitter.sv
// Self-checking bench for sum_splitter: directed scenarios plus random traffic, all compared
// every cycle against a queue-based reference model.
module tb_sum_splitter;
  localparam int WIDTH     = 8;
  localparam int CNT_WIDTH = 4;
  localparam int CNT_MAX   = (1 << CNT_WIDTH) - 1;

  // ---------------- clock / reset ----------------
  logic clock = 1'b0;
  logic reset;
  logic clear;
  logic [CNT_WIDTH-1:0] mismatch_count;
  logic error;

  always #5 clock = ~clock;

  sum_splitter_if #(.WIDTH(WIDTH)) bus ();

  sum_splitter #(.WIDTH(WIDTH), .CNT_WIDTH(CNT_WIDTH)) dut (
    .clock          (clock),
    .reset          (reset),
    .clear          (clear),
    .bus            (bus),
    .mismatch_count (mismatch_count),
    .error          (error)
  );

  // ---------------- scoreboard / reference model ----------------
  logic [WIDTH-1:0] exp_q[$];
  int               m_mc;
  bit               m_err;
  int               n_checks = 0;
  int               n_pass   = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
    end else begin
      n_pass++;
    end
  endtask

  // Compares registered outputs against the model, then advances model and DUT by one edge.
  task automatic cycle();
    logic [WIDTH-1:0] d;
    bit acc;
    bit pop;
    check("in_ready", {31'd0, bus.in_ready}, {31'd0, exp_q.size() < 2});
    check("out_valid", {31'd0, bus.out_valid}, {31'd0, exp_q.size() != 0});
    if (exp_q.size() != 0) check("out", {24'd0, bus.out}, {24'd0, exp_q[0]});
    check("mismatch_count", {28'd0, mismatch_count}, m_mc);
    check("error", {31'd0, error}, {31'd0, m_err});
    if (reset) begin
      exp_q.delete();
      m_mc  = 0;
      m_err = 0;
    end else begin
      d   = bus.sum - bus.in0;
      acc = bus.in_valid && (exp_q.size() < 2);
      pop = (exp_q.size() != 0) && bus.out_ready;
      if (pop) void'(exp_q.pop_front());
      if (acc) exp_q.push_back(d);
      if (clear) begin
        m_mc  = 0;
        m_err = 0;
      end else if (acc && d != bus.exp_in1) begin
        m_err = 1;
        m_mc  = (m_mc + 1 > CNT_MAX) ? CNT_MAX : m_mc + 1;
      end
    end
    @(posedge clock);
    #1;
  endtask

  // ---------------- driver tasks ----------------
  task automatic drive(input bit v, input int s, input int a, input int e, input bit ordy);
    bus.in_valid  = v;
    bus.sum       = WIDTH'(s);
    bus.in0       = WIDTH'(a);
    bus.exp_in1   = WIDTH'(e);
    bus.out_ready = ordy;
  endtask

  task automatic idle(input int n);
    drive(0, 0, 0, 0, 1);
    for (int i = 0; i < n; i++) cycle();
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int sums [3];
    int ins  [3];
    sums = '{3, 5, 7};
    ins  = '{1, 2, 3};
    m_mc  = 0;
    m_err = 0;
    reset = 1'b1;
    clear = 1'b0;
    drive(0, 0, 0, 0, 0);
    @(posedge clock);
    #1;
    reset = 1'b0;

    // Reset state
    check("rst_in_ready", {31'd0, bus.in_ready}, 32'd1);
    check("rst_out_valid", {31'd0, bus.out_valid}, 32'd0);
    check("rst_mcount", {28'd0, mismatch_count}, 32'd0);
    check("rst_error", {31'd0, error}, 32'd0);

    // Stream with latency 1
    for (int i = 0; i < 3; i++) begin
      drive(1, sums[i], ins[i], sums[i] - ins[i], 1);
      cycle();
      check("stream_out", {24'd0, bus.out}, 32'(sums[i] - ins[i]));
      check("stream_valid", {31'd0, bus.out_valid}, 32'd1);
    end
    idle(2);

    // Wrap-around
    drive(1, 3, 5, 254, 1);
    cycle();
    check("wrap_out", {24'd0, bus.out}, 32'd254);
    check("wrap_error", {31'd0, error}, 32'd0);
    idle(2);

    // Backpressure
    for (int i = 0; i < 4; i++) begin
      drive(1, 10 + i, 0, 10 + i, 0);
      cycle();
      if (i == 1) check("bp_in_ready_low", {31'd0, bus.in_ready}, 32'd0);
    end
    check("bp_head", {24'd0, bus.out}, 32'd10);
    drive(1, 13, 0, 13, 1);
    cycle();
    check("bp_second", {24'd0, bus.out}, 32'd11);
    check("bp_in_ready_back", {31'd0, bus.in_ready}, 32'd1);
    cycle();
    check("bp_next_accepted", {24'd0, bus.out}, 32'd13);
    idle(3);

    // Mismatch saturation, then clear against a same-cycle mismatch
    for (int i = 0; i < 20; i++) begin
      drive(1, 20 + i, 1, 0, 1);
      cycle();
      check("sat_error", {31'd0, error}, 32'd1);
    end
    check("sat_count", {28'd0, mismatch_count}, 32'(CNT_MAX));
    drive(1, 50, 1, 0, 1);
    clear = 1'b1;
    cycle();
    clear = 1'b0;
    check("clear_count", {28'd0, mismatch_count}, 32'd0);
    check("clear_error", {31'd0, error}, 32'd0);
    idle(2);

    // Reset mid-stream with a full buffer and nonzero counters
    drive(1, 30, 0, 1, 0);
    cycle();
    cycle();
    check("pre_rst_full", {31'd0, bus.in_ready}, 32'd0);
    reset = 1'b1;
    drive(1, 40, 0, 1, 0);
    cycle();
    reset = 1'b0;
    check("midrst_out_valid", {31'd0, bus.out_valid}, 32'd0);
    check("midrst_in_ready", {31'd0, bus.in_ready}, 32'd1);
    check("midrst_count", {28'd0, mismatch_count}, 32'd0);
    check("midrst_error", {31'd0, error}, 32'd0);
    drive(1, 9, 4, 5, 1);
    cycle();
    check("post_rst_out", {24'd0, bus.out}, 32'd5);
    idle(2);

    // Random traffic against the model
    for (int i = 0; i < 400; i++) begin
      int s;
      int a;
      s = int'($urandom_range(0, 255));
      a = int'($urandom_range(0, 255));
      drive($urandom_range(0, 3) != 0, s, a,
            ($urandom_range(0, 3) != 0) ? (s - a) : int'($urandom_range(0, 255)),
            $urandom_range(0, 2) != 0);
      clear = ($urandom_range(0, 29) == 0);
      reset = ($urandom_range(0, 59) == 0);
      cycle();
    end
    reset = 1'b0;
    clear = 1'b0;
    idle(3);

    // ---------------- report ----------------
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
